pdm_modulator_core: RTL and testbench



---
 rtl/pdm_pkg.sv | 20 ++
 rtl/pdm_step_timer.sv | 40 ++++
 rtl/pdm_modulator_core.sv | 91 +++++++++
 tb/tb_pdm_modulator_core.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM modulator.
// Holds the minimum step-width constant that bounds PDM_PERIOD_DIV and the
// helper that derives the step divider width from the two core parameters.
package pdm_pkg;

    // PDM_PERIOD_DIV must leave at least this many bits of clock division
    // per PDM step, i.e. PDM_PERIOD_DIV >= MOD_WIDTH + PDM_MIN_STEP.
    localparam int unsigned PDM_MIN_STEP = 1;

    // log2 of clocks per PDM step. Clamped to 1 so that an illegal
    // configuration still elaborates far enough to report its own error.
    function automatic int unsigned pdm_step(input int unsigned period_div,
                                             input int unsigned mod_width);
        if (period_div > mod_width) begin
            return period_div - mod_width;
        end
        return 1;
    endfunction

endpackage

// File: rtl/pdm_step_timer.sv
// Free-running divider for the PDM modulator.
// A PDM_PERIOD_DIV-bit counter steps every clock and wraps. It flags the
// last clock of each PDM step and of each modulation period, and registers
// a one-clock start_strobe on the cycle after the period wrap.
//
// Ports:
//   clk          in   system clock
//   nrst         in   asynchronous active-low reset
//   step_en      out  combinational: low STEP counter bits all ones
//   wrap         out  combinational: whole counter all ones (period end)
//   start_strobe out  registered one-clock pulse following each wrap
module pdm_step_timer #(
    parameter int unsigned PDM_PERIOD_DIV = 8,
    parameter int unsigned STEP           = 1
) (
    input  logic clk,
    input  logic nrst,
    output logic step_en,
    output logic wrap,
    output logic start_strobe
);

    logic [PDM_PERIOD_DIV-1:0] cnt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt          <= '0;
            start_strobe <= 1'b0;
        end else begin
            cnt          <= cnt + PDM_PERIOD_DIV'(1);
            start_strobe <= wrap;
        end
    end

    always_comb begin
        step_en = &cnt[STEP-1:0];
        wrap    = &cnt;
    end

endmodule

// File: rtl/pdm_modulator_core.sv
// First-order sigma-delta pulse-density modulator.
// Each modulation period is 2^MOD_WIDTH PDM steps of 2^STEP clocks. At the
// period wrap the setpoint is latched and the accumulator cleared; on every
// step the carry of acc + sp_q is emitted, giving exactly sp_q ones per
// period, evenly spread.
//
// Build option: define PDM_OUT_INVERT_EN to drive pdm_out as the inverse of
// the carry stream (reset value 1) for active-low loads.
//
// Ports:
//   clk          in   system clock
//   nrst         in   asynchronous active-low reset
//   mod_setpoint in   unsigned duty setpoint, latched once per period
//   pdm_out      out  registered PDM bit stream
//   start_strobe out  one-clock pulse at the start of each period
//   busy         out  high while a period runs (low during strobe and
//                     before the first period)
module pdm_modulator_core
    import pdm_pkg::*;
#(
    parameter int unsigned PDM_PERIOD_DIV = 8,
    parameter int unsigned MOD_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [MOD_WIDTH-1:0] mod_setpoint,
    output logic                 pdm_out,
    output logic                 start_strobe,
    output logic                 busy
);

    localparam int unsigned STEP = pdm_step(PDM_PERIOD_DIV, MOD_WIDTH);

`ifdef PDM_OUT_INVERT_EN
    localparam logic OUT_POLARITY = 1'b1;
`else
    localparam logic OUT_POLARITY = 1'b0;
`endif

    if (PDM_PERIOD_DIV < MOD_WIDTH + PDM_MIN_STEP) begin : g_bad_period_div
        $error("pdm_modulator_core: PDM_PERIOD_DIV must be >= MOD_WIDTH + %0d",
               PDM_MIN_STEP);
    end

    logic                 step_en;
    logic                 wrap;
    logic                 started;
    logic [MOD_WIDTH-1:0] acc;
    logic [MOD_WIDTH-1:0] sp_q;
    logic [MOD_WIDTH:0]   sum;

    pdm_step_timer #(
        .PDM_PERIOD_DIV (PDM_PERIOD_DIV),
        .STEP           (STEP)
    ) u_timer (
        .clk          (clk),
        .nrst         (nrst),
        .step_en      (step_en),
        .wrap         (wrap),
        .start_strobe (start_strobe)
    );

    always_comb begin
        sum = {1'b0, acc} + {1'b0, sp_q};
    end

    // wrap always coincides with a step_en. The final step of the period
    // still emits its carry from the old acc/sp_q; the clear and latch below
    // override only the accumulator and setpoint for the next step.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            acc     <= '0;
            sp_q    <= '0;
            pdm_out <= OUT_POLARITY;
            started <= 1'b0;
            busy    <= 1'b0;
        end else begin
            if (step_en) begin
                acc     <= sum[MOD_WIDTH-1:0];
                pdm_out <= sum[MOD_WIDTH] ^ OUT_POLARITY;
            end
            if (wrap) begin
                acc     <= '0;
                sp_q    <= mod_setpoint;
                started <= 1'b1;
            end
            busy <= started & ~wrap;
        end
    end

endmodule

// File: tb/tb_pdm_modulator_core.sv
module tb_pdm_modulator_core;

    localparam int unsigned MW    = 5;
    localparam int unsigned PDIV  = 6;
    localparam int          STEPS = 32;
    localparam int          PER   = 64;

`ifdef PDM_OUT_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    typedef struct {
        logic [31:0] pat;
        int          ones;
        int          sp;
    } exp_t;

    logic          clk;
    logic          nrst;
    logic [MW-1:0] mod_setpoint;
    logic          pdm_out;
    logic          start_strobe;
    logic          busy;

    pdm_modulator_core #(
        .PDM_PERIOD_DIV (PDIV),
        .MOD_WIDTH      (MW)
    ) dut (
        .clk          (clk),
        .nrst         (nrst),
        .mod_setpoint (mod_setpoint),
        .pdm_out      (pdm_out),
        .start_strobe (start_strobe),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    int sine[32] = '{16, 19, 21, 24, 26, 28, 30, 31, 31, 31, 30, 28, 26, 24, 21, 19,
                     16, 12, 10,  7,  5,  3,  1,  0,  0,  0,  1,  3,  5,  7, 10, 12};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: step i of a period carries iff floor(i*sp/N) increases.
    function automatic exp_t model(input int sp);
        exp_t e;
        e.pat = '0;
        for (int i = 1; i <= STEPS; i++) begin
            e.pat[i-1] = (((i * sp) / STEPS - ((i - 1) * sp) / STEPS) != 0) ^ INV;
        end
        e.ones = INV ? STEPS - sp : sp;
        e.sp   = sp;
        return e;
    endfunction

    // ---------------- monitor ----------------
    bit          mon_restart = 0;
    bit          seen_first;
    int          mcyc;
    int          pos;
    logic [31:0] pat;
    int          periods_done = 0;

    always @(negedge clk) begin
        if (!nrst || mon_restart) begin
            if (nrst) mon_restart = 0;
            seen_first = 0;
            mcyc       = 0;
            pos        = 0;
            pat        = '0;
        end else begin
            mcyc++;
            if (!seen_first) begin
                if (start_strobe) begin
                    chk("first_strobe_latency", 32'(mcyc), 32'(PER));
                    chk("busy_in_first_strobe", 32'(busy), 32'(0));
                    seen_first = 1;
                    pos        = 0;
                    pat        = '0;
                end else begin
                    chk("pre_busy", 32'(busy), 32'(0));
                    chk("pre_pdm", 32'(pdm_out), 32'(INV));
                    if (mcyc == PER + 16) chk("first_strobe_seen", 32'(start_strobe), 32'(1));
                end
            end else begin
                pos++;
                if (pos % 2 == 0) pat[pos/2-1] = pdm_out;
                if (pos < PER) begin
                    chk("strobe_low", 32'(start_strobe), 32'(0));
                    chk("busy_high", 32'(busy), 32'(1));
                end else begin
                    chk("strobe_period", 32'(start_strobe), 32'(1));
                    chk("busy_in_strobe", 32'(busy), 32'(0));
                    if (sb.size() == 0) begin
                        chk("scoreboard_nonempty", 32'(sb.size()), 32'(1));
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk($sformatf("pattern_sp%0d", e.sp), pat, e.pat);
                        chk($sformatf("ones_sp%0d", e.sp), 32'($countones(pat)), 32'(e.ones));
                        periods_done++;
                    end
                    pos = 0;
                    pat = '0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int cyc_s;
    int sidx;
    int next_chg;

    task automatic do_reset();
        @(negedge clk);
        #2 nrst = 1'b0;
        sb.delete();
        mon_restart = 1;
        #1;
        chk("rst_pdm", 32'(pdm_out), 32'(INV));
        chk("rst_strobe", 32'(start_strobe), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        #4 nrst = 1'b1;
        cyc_s = 0;
        @(negedge clk);
    endtask

    // mode 0: hold; 1: sine table step every 16 clocks; 2: random at random times
    task automatic run_cycles(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            cyc_s++;
            if (mode == 1 && (cyc_s % 16) == 0) begin
                mod_setpoint = MW'(sine[sidx]);
                sidx = (sidx + 1) % 32;
            end
            if (mode == 2 && cyc_s >= next_chg) begin
                mod_setpoint = MW'($urandom_range(0, 31));
                next_chg = cyc_s + int'($urandom_range(1, 40));
            end
            if ((cyc_s % PER) == 0) sb.push_back(model(int'(mod_setpoint)));
            @(negedge clk);
        end
    endtask

    initial begin
        nrst         = 1'b0;
        mod_setpoint = '0;
        do_reset();

        mod_setpoint = MW'(16);
        run_cycles(PER * 3, 0);
        mod_setpoint = '0;
        run_cycles(PER * 2, 0);
        mod_setpoint = MW'(31);
        run_cycles(PER * 2, 0);

        sidx = int'($urandom_range(0, 31));
        run_cycles(PER * 8, 1);

        next_chg = cyc_s + 1;
        run_cycles(PER * 6, 2);

        // Reset mid-period while the stream is mostly ones.
        mod_setpoint = MW'(31);
        run_cycles(PER + PER / 2, 0);
        chk("pre_reset_busy", 32'(busy), 32'(1));
        do_reset();

        mod_setpoint = MW'(16);
        run_cycles(PER * 2 + 4, 0);

        chk("periods_checked_min", 32'(periods_done >= 22), 32'(1));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
